wb_dma_master: RTL and testbench

Wishbone classic initiator that copies a block of 32-bit words from a source address to a destination address. It sits on the master side of the user-project bus fabric, the opposite end from the peripheral responders: it issues the cycles that the bus splitter decodes, with one read followed by one write per word. Local logic drives control through a start/length/address interface. The block reports completion with a status code.

---
 rtl/wb_dma_pkg.sv | 23 ++
 rtl/wb_dma_master_if.sv | 22 ++
 rtl/wb_ack_watchdog.sv | 30 +++
 rtl/wb_dma_master.sv | 191 +++++++++++++++++++
 tb/tb_wb_dma_master.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone block-copy initiator and its helpers.
package wb_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_GAP_R  = 3'd2,
        S_WRITE  = 3'd3,
        S_GAP_W  = 3'd4,
        S_FINISH = 3'd5
    } dma_state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_BUSERR  = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ABORT   = 2'd3
    } dma_status_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] ADDR_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/wb_dma_master_if.sv
// Wishbone classic bus bundle between an initiator (master) and the fabric (slave).
interface wb_dma_master_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/wb_ack_watchdog.sv
// Counts cycles a strobe waits for a response; flags expiry on the cycle that
// would be the TIMEOUT_CYCLES-th unanswered one. TIMEOUT_CYCLES=0 disables it.
module wb_ack_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    output logic expired
);
    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic             ENABLED = (TIMEOUT_CYCLES != 0);

    logic [TMO_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (active && ENABLED) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = ENABLED && active && !clear && (count_q == LIMIT);

endmodule

// File: rtl/wb_dma_master.sv
// Wishbone classic initiator copying LEN 32-bit words, one read then one write
// per word, with a one-cycle idle bus gap after every acknowledged access.
module wb_dma_master
    import wb_dma_pkg::*;
#(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status,
    output logic [LEN_W-1:0]     words_done,
    wb_dma_master_if.master      wbm
);

    dma_state_e      state_q;
    dma_status_e     status_q;
    logic            busy_q;
    logic            done_q;
    logic            cyc_q;
    logic            stb_q;
    logic            we_q;
    logic [3:0]      sel_q;
    logic [31:0]     adr_q;
    logic [31:0]     data_q;
    logic [31:0]     src_q;
    logic [31:0]     dst_q;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] words_q;

    logic            fin_d;
    dma_status_e     fin_code_d;
    logic            xfer_active;
    logic            on_bus;
    logic            tmo_expired;

    assign xfer_active = (state_q == S_READ) || (state_q == S_GAP_R) ||
                         (state_q == S_WRITE) || (state_q == S_GAP_W);
    assign on_bus      = (state_q == S_READ) || (state_q == S_WRITE);

    wb_ack_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!on_bus),
        .active  (stb_q && !wbm.wbm_ack_i && !wbm.wbm_err_i),
        .expired (tmo_expired)
    );

    // Termination priority: abort, then bus error, then timeout, then normal end.
    always_comb begin
        fin_d      = 1'b0;
        fin_code_d = ST_OK;
        if (state_q == S_IDLE && start && len == '0) begin
            fin_d = 1'b1;
        end else if (xfer_active && abort) begin
            fin_d      = 1'b1;
            fin_code_d = ST_ABORT;
        end else if (on_bus && wbm.wbm_err_i) begin
            fin_d      = 1'b1;
            fin_code_d = ST_BUSERR;
        end else if (on_bus && tmo_expired) begin
            fin_d      = 1'b1;
            fin_code_d = ST_TIMEOUT;
        end else if (state_q == S_GAP_W && rem_q == '0) begin
            fin_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            adr_q    <= '0;
            data_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            words_q  <= '0;
        end else begin
            done_q <= fin_d;

            // An aborted read still captures data if it was acked in the same cycle.
            if (state_q == S_READ && wbm.wbm_ack_i && (abort || !wbm.wbm_err_i)) begin
                data_q <= wbm.wbm_dat_i;
            end

            if (fin_d) begin
                state_q  <= S_FINISH;
                status_q <= fin_code_d;
                busy_q   <= 1'b0;
                cyc_q    <= 1'b0;
                stb_q    <= 1'b0;
                we_q     <= 1'b0;
                sel_q    <= 4'h0;
                if (state_q == S_IDLE) begin
                    words_q <= '0;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            src_q    <= src_addr & ADDR_MASK;
                            dst_q    <= dst_addr & ADDR_MASK;
                            rem_q    <= len;
                            words_q  <= '0;
                            status_q <= ST_OK;
                            busy_q   <= 1'b1;
                            state_q  <= S_READ;
                            cyc_q    <= 1'b1;
                            stb_q    <= 1'b1;
                            we_q     <= 1'b0;
                            sel_q    <= 4'hF;
                            adr_q    <= src_addr & ADDR_MASK;
                        end
                    end
                    S_READ: begin
                        if (wbm.wbm_ack_i) begin
                            state_q <= S_GAP_R;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            sel_q   <= 4'h0;
                        end
                    end
                    S_GAP_R: begin
                        state_q <= S_WRITE;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        sel_q   <= 4'hF;
                        adr_q   <= dst_q;
                    end
                    S_WRITE: begin
                        if (wbm.wbm_ack_i) begin
                            words_q <= words_q + 1'b1;
                            src_q   <= src_q + WORD_BYTES;
                            dst_q   <= dst_q + WORD_BYTES;
                            rem_q   <= rem_q - 1'b1;
                            state_q <= S_GAP_W;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            we_q    <= 1'b0;
                            sel_q   <= 4'h0;
                        end
                    end
                    S_GAP_W: begin
                        state_q <= S_READ;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        sel_q   <= 4'hF;
                        adr_q   <= src_q;
                    end
                    S_FINISH: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign status        = status_q;
    assign words_done    = words_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = data_q;

endmodule

// File: tb/tb_wb_dma_master.sv
// Directed bench for wb_dma_master with a configurable wait-state/error responder.
module tb_wb_dma_master;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [LEN_W-1:0] words_done;

    wb_dma_master_if wbm();

    wb_dma_master #(
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (8),
        .TMO_W          (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .words_done (words_done),
        .wbm        (wbm)
    );

    always #5 clk = ~clk;

    // Responder: ack after ack_delay waiting cycles, optional error on write number err_write.
    int   ack_delay = 0;
    int   err_write = -1;
    bit   no_ack    = 1'b0;
    int   wait_cnt  = 0;
    int   write_cnt = 0;
    logic rdy;
    logic err_hit;

    always_comb begin
        rdy           = wbm.wbm_cyc_o && wbm.wbm_stb_o && (wait_cnt == ack_delay);
        err_hit       = rdy && wbm.wbm_we_o && (write_cnt == err_write);
        wbm.wbm_ack_i = rdy && !no_ack && !err_hit;
        wbm.wbm_err_i = err_hit;
        wbm.wbm_dat_i = (wbm.wbm_adr_o == 32'h3000_0000) ? 32'hDEAD_BEEF : ~wbm.wbm_adr_o;
    end

    always_ff @(posedge clk) begin
        if (wbm.wbm_stb_o && !wbm.wbm_ack_i && !wbm.wbm_err_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (start) write_cnt <= 0;
        else if (wbm.wbm_stb_o && wbm.wbm_we_o && (wbm.wbm_ack_i || wbm.wbm_err_i))
            write_cnt <= write_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    logic [31:0] acc_adr[$];
    logic [31:0] acc_dat[$];
    logic        acc_we[$];
    int          gaps[$];
    int          rd_starts, wr_starts, stb_cycles, gap_cnt;
    bit          seen_acc, prev_stb, busy1;

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int abort_rd, output int lat);
        acc_adr.delete(); acc_dat.delete(); acc_we.delete(); gaps.delete();
        rd_starts = 0; wr_starts = 0; stb_cycles = 0; gap_cnt = 0;
        seen_acc = 0; prev_stb = 0; busy1 = 0;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            lat++;
            if (lat == 1) busy1 = busy;
            if (wbm.wbm_stb_o) begin
                stb_cycles++;
                if (!prev_stb) begin
                    if (wbm.wbm_we_o) wr_starts++; else rd_starts++;
                    if (seen_acc) gaps.push_back(gap_cnt);
                    gap_cnt = 0;
                    seen_acc = 1;
                end
                if (wbm.wbm_ack_i && !wbm.wbm_err_i) begin
                    acc_we.push_back(wbm.wbm_we_o);
                    acc_adr.push_back(wbm.wbm_adr_o);
                    acc_dat.push_back(wbm.wbm_we_o ? wbm.wbm_dat_o : wbm.wbm_dat_i);
                    chk("sel", {28'd0, wbm.wbm_sel_o}, 32'hF);
                end
                if (abort_rd > 0 && !wbm.wbm_we_o && !prev_stb && rd_starts == abort_rd) begin
                    abort = 1'b1;
                    start = 1'b1;
                end
            end else begin
                gap_cnt++;
            end
            prev_stb = wbm.wbm_stb_o;
            if (done) break;
        end
        if (!done) chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_acc(input string tag, input int idx, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat);
        if (idx >= acc_adr.size()) begin
            chk({tag, "_count"}, acc_adr.size(), idx + 1);
        end else begin
            chk({tag, "_we"},  {31'd0, acc_we[idx]}, {31'd0, we});
            chk({tag, "_adr"}, acc_adr[idx], adr);
            chk({tag, "_dat"}, acc_dat[idx], dat);
        end
    endtask

    int lat;
    logic [31:0] exp_adr [6];
    logic [31:0] exp_dat [6];

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cyc",    {31'd0, wbm.wbm_cyc_o}, 32'd0);
        chk("rst_stb",    {31'd0, wbm.wbm_stb_o}, 32'd0);
        chk("rst_we",     {31'd0, wbm.wbm_we_o}, 32'd0);
        chk("rst_sel",    {28'd0, wbm.wbm_sel_o}, 32'd0);
        chk("rst_adr",    wbm.wbm_adr_o, 32'd0);
        chk("rst_dat",    wbm.wbm_dat_o, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_status", {30'd0, status}, 32'd0);
        chk("rst_words",  {16'd0, words_done}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_cyc", {31'd0, wbm.wbm_cyc_o}, 32'd0);
        end

        // Basic single-word copy, zero wait states
        run(32'h3000_0000, 32'h3001_0000, 16'd1, 0, lat);
        chk("basic_lat",    lat, 32'd5);
        chk("basic_busy1",  {31'd0, busy1}, 32'd1);
        chk("basic_busy_f", {31'd0, busy}, 32'd0);
        chk("basic_status", {30'd0, status}, 32'd0);
        chk("basic_words",  {16'd0, words_done}, 32'd1);
        chk_acc("basic_r", 0, 1'b0, 32'h3000_0000, 32'hDEAD_BEEF);
        chk_acc("basic_w", 1, 1'b1, 32'h3001_0000, 32'hDEAD_BEEF);
        chk("basic_gaps", gaps.size(), 32'd1);
        @(negedge clk);
        chk("basic_done_pulse", {31'd0, done}, 32'd0);
        chk("basic_status_hold", {30'd0, status}, 32'd0);

        // Three words with two wait states per access
        ack_delay = 2;
        run(32'h3000_0000, 32'h3001_0000, 16'd3, 0, lat);
        exp_adr = '{32'h3000_0000, 32'h3001_0000, 32'h3000_0004,
                    32'h3001_0004, 32'h3000_0008, 32'h3001_0008};
        exp_dat = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hCFFF_FFFB,
                    32'hCFFF_FFFB, 32'hCFFF_FFF7, 32'hCFFF_FFF7};
        for (int i = 0; i < 6; i++) chk_acc("ws", i, i[0], exp_adr[i], exp_dat[i]);
        chk("ws_ngaps", gaps.size(), 32'd5);
        for (int i = 0; i < gaps.size(); i++) chk("ws_gap", gaps[i], 32'd1);
        chk("ws_lat",    lat, 32'd25);
        chk("ws_status", {30'd0, status}, 32'd0);
        chk("ws_words",  {16'd0, words_done}, 32'd3);

        // Zero-length request
        ack_delay = 0;
        run(32'h3000_0000, 32'h3001_0000, 16'd0, 0, lat);
        chk("len0_lat",    lat, 32'd1);
        chk("len0_stb",    stb_cycles, 32'd0);
        chk("len0_busy",   {31'd0, busy1}, 32'd0);
        chk("len0_status", {30'd0, status}, 32'd0);

        // Timeout on the read
        no_ack = 1'b1;
        run(32'h3000_0000, 32'h3001_0000, 16'd1, 0, lat);
        chk("tmo_stb_cycles", stb_cycles, 32'd8);
        chk("tmo_lat",    lat, 32'd9);
        chk("tmo_status", {30'd0, status}, 32'd2);
        chk("tmo_words",  {16'd0, words_done}, 32'd0);
        chk("tmo_cyc",    {31'd0, wbm.wbm_cyc_o}, 32'd0);
        no_ack = 1'b0;

        // Bus error on the second write
        err_write = 1;
        run(32'h3000_0000, 32'h3001_0000, 16'd4, 0, lat);
        chk("err_status", {30'd0, status}, 32'd1);
        chk("err_words",  {16'd0, words_done}, 32'd1);
        chk("err_lat",    lat, 32'd8);
        chk("err_cyc",    {31'd0, wbm.wbm_cyc_o}, 32'd0);
        err_write = -1;

        // Abort at the third read, with an overlapping start
        ack_delay = 1;
        run(32'h3000_0000, 32'h3001_0000, 16'd4, 3, lat);
        chk("abort_status", {30'd0, status}, 32'd3);
        chk("abort_words",  {16'd0, words_done}, 32'd2);
        chk("abort_reads",  rd_starts, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_idle_cyc",  {31'd0, wbm.wbm_cyc_o}, 32'd0);
            chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        end
        ack_delay = 0;

        // Address wrap past 2^32
        run(32'hFFFF_FFFC, 32'h0000_0010, 16'd2, 0, lat);
        chk_acc("wrap_r0", 0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0003);
        chk_acc("wrap_w0", 1, 1'b1, 32'h0000_0010, 32'h0000_0003);
        chk_acc("wrap_r1", 2, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
        chk_acc("wrap_w1", 3, 1'b1, 32'h0000_0014, 32'hFFFF_FFFF);
        chk("wrap_status", {30'd0, status}, 32'd0);
        chk("wrap_words",  {16'd0, words_done}, 32'd2);

        // Asynchronous reset in the middle of a stalled read
        no_ack = 1'b1;
        @(negedge clk);
        start = 1'b1; src_addr = 32'h3000_0000; dst_addr = 32'h3001_0000; len = 16'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("arst_pre_stb", {31'd0, wbm.wbm_stb_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc",  {31'd0, wbm.wbm_cyc_o}, 32'd0);
        chk("arst_stb",  {31'd0, wbm.wbm_stb_o}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_done", {31'd0, done}, 32'd0);
            chk("arst_idle_cyc", {31'd0, wbm.wbm_cyc_o}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
